// File: rtl/sync_fifo_ctrl_if.sv
// Handshake/status bundle for sync_fifo_ctrl.
// SYNC_FIFO_WATERMARK_EN adds the max_count peak-occupancy signal.
interface sync_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   af_level;
  logic [ADDR_WIDTH:0]   ae_level;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;
`ifdef SYNC_FIFO_WATERMARK_EN
  logic [ADDR_WIDTH:0]   max_count;

  modport master (
    output wr_en, wr_data, rd_en, af_level, ae_level, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow, max_count
  );

  modport slave (
    input  wr_en, wr_data, rd_en, af_level, ae_level, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow, max_count
  );
`else
  modport master (
    output wr_en, wr_data, rd_en, af_level, ae_level, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, af_level, ae_level, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
`endif
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, programmable thresholds, sticky errors
// and standard/FWFT read modes. SYNC_FIFO_WATERMARK_EN adds a peak-count register.
module sync_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter bit          FWFT       = 1'b0
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_ctrl_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         count_q;
  logic [PW-1:0]         count_next;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  full_c;
  logic                  empty_c;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status flags decode straight from the registered occupancy
  assign full_c  = (count_q == PW'(DEPTH));
  assign empty_c = (count_q == '0);
  assign wr_acc  = bus.wr_en && !full_c;
  assign rd_acc  = bus.rd_en && !empty_c;

  always_comb begin
    count_next = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_next = count_q + PW'(1);
      2'b01:   count_next = count_q - PW'(1);
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      count_q     <= count_next;
      // A new error in the same cycle as clr_err keeps the flag set
      overflow_q  <= (bus.wr_en && full_c)  || (overflow_q  && !bus.clr_err);
      underflow_q <= (bus.rd_en && empty_c) || (underflow_q && !bus.clr_err);
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.wr_data;
  end

  generate
    if (FWFT) begin : g_fwft
      assign bus.rd_data  = mem[rd_ptr[ADDR_WIDTH-1:0]];
      assign bus.rd_valid = !empty_c;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
      end

      assign bus.rd_data  = rd_data_q;
      assign bus.rd_valid = rd_valid_q;
    end
  endgenerate

  assign bus.count        = count_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (count_q >= bus.af_level);
  assign bus.almost_empty = (count_q <= bus.ae_level);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

`ifdef SYNC_FIFO_WATERMARK_EN
  logic [PW-1:0] max_count_q;

  // Peak tracks post-update occupancy; clr_err restarts it from that value
  always_ff @(posedge clk) begin
    if (rst) begin
      max_count_q <= '0;
    end else if (bus.clr_err) begin
      max_count_q <= count_next;
    end else if (count_next > max_count_q) begin
      max_count_q <= count_next;
    end
  end

  assign bus.max_count = max_count_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed + random bench: a standard-read and an FWFT instance share the same
// stimulus and are both checked against one queue-based reference model.
module tb_sync_fifo_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  logic wr_en;
  logic [DW-1:0] wr_data;
  logic rd_en;
  logic clr_err;
  logic [AW:0] af_level;
  logic [AW:0] ae_level;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic          m_ov;
  logic          m_un;
  logic [DW-1:0] m_rd_data;
  logic          m_rd_valid;
  int            m_max;

  always #5 clk = ~clk;

  sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_std ();
  sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_fwft ();

  assign if_std.wr_en     = wr_en;
  assign if_std.wr_data   = wr_data;
  assign if_std.rd_en     = rd_en;
  assign if_std.clr_err   = clr_err;
  assign if_std.af_level  = af_level;
  assign if_std.ae_level  = ae_level;
  assign if_fwft.wr_en    = wr_en;
  assign if_fwft.wr_data  = wr_data;
  assign if_fwft.rd_en    = rd_en;
  assign if_fwft.clr_err  = clr_err;
  assign if_fwft.af_level = af_level;
  assign if_fwft.ae_level = ae_level;

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b0)) dut_std (
    .clk(clk), .rst(rst), .bus(if_std)
  );

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b1)) dut_fwft (
    .clk(clk), .rst(rst), .bus(if_fwft)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model advance for one clock edge, from the inputs presented before it
  task automatic model_edge();
    int  sz;
    bit  wr_ok;
    bit  rd_ok;
    sz = q.size();
    if (rst) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
      m_rd_data = '0;
      m_rd_valid = 1'b0;
      m_max = 0;
      return;
    end
    wr_ok = wr_en && (sz < DEPTH);
    rd_ok = rd_en && (sz > 0);
    m_rd_valid = rd_ok;
    if (rd_ok) m_rd_data = q.pop_front();
    if (wr_ok) q.push_back(wr_data);
    m_ov = (wr_en && sz == DEPTH) ? 1'b1 : (clr_err ? 1'b0 : m_ov);
    m_un = (rd_en && sz == 0)     ? 1'b1 : (clr_err ? 1'b0 : m_un);
    if (clr_err) m_max = q.size();
    else if (q.size() > m_max) m_max = q.size();
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    chk("count",        32'(if_std.count),        32'(sz));
    chk("full",         32'(if_std.full),         32'(sz == DEPTH));
    chk("empty",        32'(if_std.empty),        32'(sz == 0));
    chk("almost_full",  32'(if_std.almost_full),  32'(sz >= int'(af_level)));
    chk("almost_empty", 32'(if_std.almost_empty), 32'(sz <= int'(ae_level)));
    chk("overflow",     32'(if_std.overflow),     32'(m_ov));
    chk("underflow",    32'(if_std.underflow),    32'(m_un));
    chk("rd_valid",     32'(if_std.rd_valid),     32'(m_rd_valid));
    chk("rd_data",      32'(if_std.rd_data),      32'(m_rd_data));
    chk("fwft_count",   32'(if_fwft.count),       32'(sz));
    chk("fwft_rd_valid", 32'(if_fwft.rd_valid),   32'(sz > 0));
    if (sz > 0) chk("fwft_rd_data", 32'(if_fwft.rd_data), 32'(q[0]));
`ifdef SYNC_FIFO_WATERMARK_EN
    chk("max_count",    32'(if_std.max_count),    32'(m_max));
`endif
  endtask

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic c, input logic rs);
    wr_en = w; wr_data = d; rd_en = r; clr_err = c; rst = rs;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; clr_err = 1'b0; rst = 1'b1;
    af_level = 5'd14; ae_level = 5'd2;
    q.delete(); m_ov = 1'b0; m_un = 1'b0; m_rd_data = '0; m_rd_valid = 1'b0; m_max = 0;

    // Reset values
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("rst_empty", 32'(if_std.empty), 32'd1);
    chk("rst_almost_full", 32'(if_std.almost_full), 32'd0);

    // Fill 0x01..0x10, then drain in order
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_full", 32'(if_std.full), 32'd1);
    chk("fill_no_overflow", 32'(if_std.overflow), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("drain_data", 32'(if_std.rd_data), 32'(i));
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rd_valid_single", 32'(if_std.rd_valid), 32'd0);
    chk("drain_empty", 32'(if_std.empty), 32'd1);

    // Overflow while full, cleared by clr_err, 0xAA never stored
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(if_std.overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("ovf_clr", 32'(if_std.overflow), 32'd0);
    // Full with simultaneous write and read: only the read lands
    step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    chk("full_wr_rd_count", 32'(if_std.count), 32'(DEPTH - 1));
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Underflow, set-wins against clr_err
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("unf_set", 32'(if_std.underflow), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("unf_set_wins", 32'(if_std.underflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("unf_clr", 32'(if_std.underflow), 32'd0);

    // Steady occupancy of 5 with concurrent traffic across pointer wraps
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h85 + i), 1'b1, 1'b0, 1'b0);
    chk("steady_count", 32'(if_std.count), 32'd5);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // FWFT: word appears without rd_en, then popped
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("fwft_show_valid", 32'(if_fwft.rd_valid), 32'd1);
    chk("fwft_show_data", 32'(if_fwft.rd_data), 32'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("fwft_pop_empty", 32'(if_fwft.empty), 32'd1);
    chk("fwft_pop_valid", 32'(if_fwft.rd_valid), 32'd0);

    // Reset mid-operation with traffic requested
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
`ifdef SYNC_FIFO_WATERMARK_EN
    chk("wm_before_rst", 32'(if_std.max_count), 32'd8);
`endif
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
    chk("rst_mid_count", 32'(if_std.count), 32'd0);
    chk("rst_mid_empty", 32'(if_std.empty), 32'd1);
`ifdef SYNC_FIFO_WATERMARK_EN
    chk("wm_after_rst", 32'(if_std.max_count), 32'd0);
`endif

    // Randomised traffic with moving thresholds, occasional clr_err/rst
    for (int i = 0; i < 600; i++) begin
      if ((i % 50) == 0) begin
        af_level = 5'($urandom_range(0, 18));
        ae_level = 5'($urandom_range(0, 18));
      end
      step(1'($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 65 : 35)),
           8'($urandom),
           1'($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 65)),
           1'($urandom_range(0, 99) < 5),
           1'($urandom_range(0, 299) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock, parametrised FIFO. It is the next generation of the team's FIFO buffer, used wherever producer and consumer share one clock domain. It adds the following over the basic full/empty FIFO:
- occupancy count
- programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- selectable standard or first-word-fall-through (FWFT) read mode
Storage is an inferred register array of depth 2^ADDR_WIDTH.

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2^ADDR_WIDTH
FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
wr_en  input  1  write request
wr_data  input  DATA_WIDTH  write data
rd_en  input  1  read request (pop)
rd_data  output  DATA_WIDTH  read data
rd_valid  output  1  rd_data holds a valid word (meaning depends on FWFT)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= af_level
almost_empty  output  1  count <= ae_level
af_level  input  ADDR_WIDTH+1  almost-full threshold, quasi-static
ae_level  input  ADDR_WIDTH+1  almost-empty threshold, quasi-static
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty
clr_err  input  1  clears overflow/underflow

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst; it is sampled only on the clk rising edge.
- Reset values:
  - wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0
  - rd_data = 0, rd_valid = 0 (FWFT=1: rd_valid = 0 because the FIFO is empty)
  - overflow = underflow = 0
  - almost_empty = 1; almost_full = (af_level == 0)
  - Memory contents are not reset.
- Reset asserted mid-operation discards all stored data. The FIFO is empty on the next cycle regardless of wr_en/rd_en in the reset cycle.
- Pointers are ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits index memory. Pointers increment modulo 2^(ADDR_WIDTH+1), so wrap-around is natural.
- Write accepted iff wr_en && !full: mem[wr_ptr] <= wr_data, wr_ptr +1.
- Read accepted iff rd_en && !empty: rd_ptr +1.
- count is registered:
  - +1 on write only, -1 on read only.
  - Unchanged when both are accepted in the same cycle, or when neither is.
- empty, full, almost_full and almost_empty are decoded combinationally from registered count. A write in cycle N is therefore reflected on the flags in cycle N+1.
- A write while full is dropped with no pointer or data change, and it sets overflow.
- A read while empty is dropped and sets underflow.
- Full plus simultaneous wr_en and rd_en: only the read is accepted, count becomes DEPTH-1, and overflow is set.
- overflow and underflow hold until clr_err. If clr_err and a new error occur in the same cycle, the flag stays set (set wins).
- FWFT=0 (standard read mode):
  - An accepted read in cycle N registers mem[rd_ptr] onto rd_data at edge N+1, and rd_valid = 1 for exactly that cycle.
  - rd_data holds its value when no read is accepted.
- FWFT=1 (first-word-fall-through):
  - rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]] combinationally and rd_valid = !empty.
  - rd_en acts as an acknowledge/pop of the displayed word.
  - A word written to an empty FIFO in cycle N appears with rd_valid = 1 in cycle N+1.
- Thresholds:
  - af_level > DEPTH means almost_full is never asserted.
  - ae_level >= DEPTH means almost_empty is always asserted.
  - Threshold changes take effect combinationally.

Optional Feature:
Macro SYNC_FIFO_WATERMARK_EN.
- Defined:
  - Adds output max_count [ADDR_WIDTH:0], a registered peak of count.
  - Updated each cycle with the post-update occupancy if greater.
  - Reset to 0 by rst; reset to the current count by clr_err.
- Undefined: the port and logic are absent, and all other behaviour is identical.

Test Plan:
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=4, FWFT=0, af_level=14, ae_level=2.
- Reset, then write 0x01..0x10 on 16 consecutive cycles -> count = 16, full = 1, almost_full asserted from count 14, no overflow; then 16 reads -> rd_data 0x01..0x10 in order, each one cycle after its rd_en, with a single-cycle rd_valid; empty = 1 at the end.
- At full, hold wr_en with data 0xAA for 2 cycles -> count stays 16 and overflow = 1; 0xAA is never read out; clr_err pulse -> overflow = 0.
- Empty FIFO, rd_en = 1 -> underflow = 1, rd_valid = 0, count = 0; clr_err and a read while empty in the same cycle -> underflow stays 1.
- Count = 5, simultaneous wr_en/rd_en for 40 cycles with an incrementing data pattern -> count stays 5, pointers wrap at least twice, and read data order is preserved.
- FWFT=1: write 0x3C into an empty FIFO -> next cycle rd_valid = 1 and rd_data = 0x3C before any rd_en; rd_en = 1 -> empty = 1 and rd_valid = 0 on the following cycle.
- Write 8 words, assert rst for 1 cycle while wr_en = rd_en = 1 -> next cycle count = 0, empty = 1, flags cleared; with SYNC_FIFO_WATERMARK_EN, max_count = 8 before reset and 0 after.
